// File: rtl/mem_port_arbiter.sv
// Two-port word memory arbiter. Port 0 is the core and port 1 is the loader/debug port.
// Arbitration is round-robin, or fixed priority to port 0 when FIXED_PRIO=1.
// Grants and memory strobes are combinational in IDLE.
// A read holds the arbiter in RD_WAIT for one cycle while the memory returns data.
// A misaligned access is granted without a memory strobe, and its error is pulsed one cycle later.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic          err0,
  output logic          err1,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic {IDLE = 1'b0, RD_WAIT = 1'b1} state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;   // port granted most recently
  logic       rd_id_q, rd_id_d; // port owning the outstanding read
  logic [1:0] err_q, err_d;

  logic          win;
  logic          any_req;
  logic          grant;
  logic          aligned;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  // Winner selection. On a tie, round-robin picks the port that did not win last time.
  always_comb begin
    any_req = req0 | req1;
    if (req0 && req1) win = FIXED_PRIO ? 1'b0 : ~last_q;
    else              win = req1 & ~req0;
    win_we    = win ? we1    : we0;
    win_addr  = win ? addr1  : addr0;
    win_wdata = win ? wdata1 : wdata0;
    aligned   = (win_addr[1:0] == 2'b00);
    // The rst gate keeps gnt and mem_en low for the whole time reset is asserted.
    grant     = rst & (state_q == IDLE) & any_req;
  end

  // Output decode: grant strobes in IDLE, and read return in RD_WAIT.
  always_comb begin
    gnt0      = grant & ~win;
    gnt1      = grant &  win;
    mem_en    = grant & aligned;
    mem_we    = win_we;
    mem_addr  = win_addr;
    mem_wdata = win_wdata;
    busy      = (state_q == RD_WAIT);
    rvalid0   = busy & ~rd_id_q;
    rvalid1   = busy &  rd_id_q;
    rdata     = busy ? mem_rdata : '0;
    err0      = err_q[0];
    err1      = err_q[1];
  end

  // Next-state logic. Aligned reads go to RD_WAIT. Misaligned grants raise the error pulse.
  always_comb begin
    state_d = IDLE;
    last_d  = last_q;
    rd_id_d = rd_id_q;
    err_d   = 2'b00;
    if (grant) begin
      last_d = win;
      if (!aligned) begin
        err_d[win] = 1'b1;
      end else if (!win_we) begin
        state_d = RD_WAIT;
        rd_id_d = win;
      end
    end
  end

  // State registers. Reset drops any outstanding read and makes port 0 win the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      rd_id_q <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      rd_id_q <= rd_id_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. A round-robin instance and a fixed-priority instance share the same stimulus.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1, mem_rdata;

  logic          gnt0, gnt1, rvalid0, rvalid1, err0, err1, mem_en, mem_we, busy;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  logic          f_gnt0, f_gnt1, f_rvalid0, f_rvalid1, f_err0, f_err1, f_mem_en, f_mem_we, f_busy;
  logic [DW-1:0] f_rdata, f_mem_wdata;
  logic [AW-1:0] f_mem_addr;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .err0(err0), .err1(err1), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy));

  mem_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(f_gnt0), .gnt1(f_gnt1), .rvalid0(f_rvalid0), .rvalid1(f_rvalid1),
    .err0(f_err0), .err1(f_err1), .rdata(f_rdata), .mem_en(f_mem_en), .mem_we(f_mem_we),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_rdata(mem_rdata), .busy(f_busy));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge. Checks run 1 time unit later, away from the rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
  endtask

  initial begin
    rst = 1'b0; idle_inputs();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_rdata = '0;

    // A request is held during reset, but no output may respond to it.
    req0 = 1; we0 = 1; addr0 = 32'h0;
    step(); #1;
    chk("rst_gnt0",   gnt0,   1'b0);
    chk("rst_mem_en", mem_en, 1'b0);
    chk("rst_busy",   busy,   1'b0);
    chk("rst_rvalid", {rvalid0, rvalid1, err0, err1}, 4'b0);
    chk("rst_rdata",  rdata,  32'h0);
    idle_inputs();
    step(); rst = 1'b1;

    // Port 0 reads 0x10. The grant cycle comes first, then the data cycle.
    step(); req0 = 1; we0 = 0; addr0 = 32'h10; #1;
    chk("rd_gnt0",     gnt0,     1'b1);
    chk("rd_mem_en",   mem_en,   1'b1);
    chk("rd_mem_we",   mem_we,   1'b0);
    chk("rd_mem_addr", mem_addr, 32'h10);
    step(); idle_inputs(); mem_rdata = 32'hDEADBEEF; #1;
    chk("rd_rvalid0", rvalid0, 1'b1);
    chk("rd_rdata",   rdata,   32'hDEADBEEF);
    chk("rd_busy",    busy,    1'b1);
    chk("rd_no_en",   mem_en,  1'b0);
    step(); #1;
    chk("rd_done",    {rvalid0, busy}, 2'b00);
    chk("rd_rdata0",  rdata,   32'h0);

    // Both ports write continuously from reset. Round-robin gives 0,1,0, and fixed priority always gives port 0.
    rst = 1'b0; step(); rst = 1'b1;
    step(); req0 = 1; we0 = 1; addr0 = 32'h20; wdata0 = 32'hA0A0;
            req1 = 1; we1 = 1; addr1 = 32'h24; wdata1 = 32'hB1B1; #1;
    chk("rr1_gnt",   {gnt0, gnt1}, 2'b10);
    chk("rr1_addr",  mem_addr,  32'h20);
    chk("rr1_we",    {mem_en, mem_we}, 2'b11);
    chk("fp1_gnt",   {f_gnt0, f_gnt1}, 2'b10);
    step(); #1;
    chk("rr2_gnt",   {gnt0, gnt1}, 2'b01);
    chk("rr2_wdata", mem_wdata, 32'hB1B1);
    chk("rr2_we",    {mem_en, mem_we}, 2'b11);
    chk("fp2_gnt",   {f_gnt0, f_gnt1}, 2'b10);
    step(); #1;
    chk("rr3_gnt",   {gnt0, gnt1}, 2'b10);
    chk("rr3_we",    {mem_en, mem_we}, 2'b11);
    chk("fp3_gnt",   {f_gnt0, f_gnt1}, 2'b10);
    chk("fp3_addr",  f_mem_addr, 32'h20);

    // Port 1 makes a misaligned read. It is granted with no strobe, and the error pulses for exactly one cycle.
    step(); idle_inputs(); req1 = 1; we1 = 0; addr1 = 32'h6; #1;
    chk("mis_gnt1",   gnt1,   1'b1);
    chk("mis_mem_en", mem_en, 1'b0);
    chk("mis_err_now", err1,  1'b0);
    step(); idle_inputs(); #1;
    chk("mis_err1",   {err1, err0}, 2'b10);
    chk("mis_rv1",    rvalid1, 1'b0);
    step(); #1;
    chk("mis_err_off", err1,  1'b0);
    chk("mis_rv1b",   rvalid1, 1'b0);

    // Port 1 requests while port 0's read is outstanding. Port 1 is granted only in the next IDLE cycle.
    step(); req0 = 1; we0 = 0; addr0 = 32'h40; #1;
    chk("ov_gnt0", gnt0, 1'b1);
    step(); req0 = 0; req1 = 1; we1 = 1; addr1 = 32'h44; wdata1 = 32'h5555; mem_rdata = 32'h1234; #1;
    chk("ov_wait_gnt", {gnt0, gnt1}, 2'b00);
    chk("ov_rvalid0",  rvalid0, 1'b1);
    chk("ov_rdata",    rdata,   32'h1234);
    step(); #1;
    chk("ov_gnt1",  gnt1,     1'b1);
    chk("ov_addr",  mem_addr, 32'h44);
    chk("ov_we",    {mem_en, mem_we}, 2'b11);
    chk("ov_rv",    {rvalid0, rvalid1}, 2'b00);

    // Port 0 reads, and reset is asserted during RD_WAIT. The read is dropped and no rvalid follows.
    step(); idle_inputs(); req0 = 1; we0 = 0; addr0 = 32'h8; #1;
    chk("rr_gnt0", gnt0, 1'b1);
    step(); idle_inputs(); mem_rdata = 32'hCAFEF00D; #1;
    chk("rr_rv0", rvalid0, 1'b1);
    #2 rst = 1'b0; #1;
    chk("rr_rst_rv",   {rvalid0, busy, mem_en, gnt0, gnt1}, 5'b0);
    chk("rr_rst_data", rdata, 32'h0);
    step(); rst = 1'b1;
    step(); #1;
    chk("rr_after_rv", {rvalid0, rvalid1, busy}, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Watchdog: every step above is bounded, but a stall must still end in the summary path.
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end
endmodule
